// File: rtl/fofb_data_dpram_lanes.sv
// fofb_data_dpram_lanes: multi-lane dual-port RAM with per-lane writes, read latency 1/2 and clear sequencer
module fofb_data_dpram_lanes #(
  parameter int ADDR_WIDTH     = 9,
  parameter int LANE_WIDTH     = 32,
  parameter int LANE_COUNT     = 3,
  parameter int READ_LATENCY   = 1,
  parameter bit CLEAR_ON_RESET = 1'b1
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             wea,
  input  logic [LANE_COUNT-1:0]            wlane,
  input  logic [ADDR_WIDTH-1:0]            addra,
  input  logic [LANE_COUNT*LANE_WIDTH-1:0] dina,
  input  logic                             renb,
  input  logic [ADDR_WIDTH-1:0]            addrb,
  output logic [LANE_COUNT*LANE_WIDTH-1:0] doutb,
  output logic                             doutbValid,
  input  logic                             clearReq,
  output logic                             clearBusy,
  output logic                             writeDropped,
  input  logic                             dropAck
);
  localparam int DATA_WIDTH = LANE_COUNT * LANE_WIDTH;
  localparam int DEPTH = 1 << ADDR_WIDTH;
  typedef enum logic {IDLE, CLEAR} state_t;
  state_t state_q, state_d;
  logic [ADDR_WIDTH-1:0] clr_q, clr_d;
  logic [DATA_WIDTH-1:0] ram_q;
  logic busy, v1_q, drop_d;
  assign busy = state_q == CLEAR;
  assign clearBusy = busy;
  // clear sequencing: leave CLEAR after the all-ones address, requests ignored while busy
  always_comb begin
    state_d = busy ? (&clr_q ? IDLE : CLEAR) : (clearReq ? CLEAR : IDLE);
    clr_d = busy ? clr_q + 1'b1 : '0;
    drop_d = (busy && wea) ? 1'b1 : (dropAck ? 1'b0 : writeDropped);
  end
  // control registers; the array itself is never reset
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= CLEAR_ON_RESET ? CLEAR : IDLE;
      clr_q <= '0;
      writeDropped <= 1'b0;
      v1_q <= 1'b0;
    end else begin
      state_q <= state_d;
      clr_q <= clr_d;
      writeDropped <= drop_d;
      v1_q <= renb;
    end
  end
  for (genvar g = 0; g < LANE_COUNT; g++) begin : g_lane
    logic [LANE_WIDTH-1:0] mem [DEPTH];
    logic [LANE_WIDTH-1:0] rd_q;
    // one block RAM per lane; the clear sequencer owns the write port while busy, read-first
    always_ff @(posedge clk) begin
      if (busy || (wea && wlane[g])) mem[busy ? clr_q : addra] <= busy ? '0 : dina[g*LANE_WIDTH +: LANE_WIDTH];
      if (renb) rd_q <= mem[addrb];
    end
    assign ram_q[g*LANE_WIDTH +: LANE_WIDTH] = rd_q;
  end
  if (READ_LATENCY == 1) begin : g_rl1
    logic seen_q;
    // RAM output is not resettable, so mask it to zero until the first read lands
    always_ff @(posedge clk or posedge reset) begin
      if (reset) seen_q <= 1'b0;
      else if (renb) seen_q <= 1'b1;
    end
    assign doutb = seen_q ? ram_q : '0;
    assign doutbValid = v1_q;
  end else if (READ_LATENCY == 2) begin : g_rl2
    logic [DATA_WIDTH-1:0] out_q;
    logic v2_q;
    // extra output stage, loaded only on a valid so the last result is held
    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        out_q <= '0;
        v2_q <= 1'b0;
      end else begin
        v2_q <= v1_q;
        if (v1_q) out_q <= ram_q;
      end
    end
    assign doutb = out_q;
    assign doutbValid = v2_q;
  end else begin : g_bad_latency
    $error("fofb_data_dpram_lanes: READ_LATENCY must be 1 or 2");
  end
endmodule

// File: tb/tb_fofb_data_dpram_lanes.sv
// tb_fofb_data_dpram_lanes: directed checks of a latency-1 clear-on-reset instance and a latency-2 plain instance
module tb_fofb_data_dpram_lanes;
  logic clk, reset, wea, renb, clearReq, dropAck;
  logic [2:0] wlane;
  logic [3:0] addra, addrb;
  logic [95:0] dina, d1, d2;
  logic v1, v2, b1, b2, wd1, wd2;
  int tests = 0;
  int fails = 0;
  int n;

  fofb_data_dpram_lanes #(.ADDR_WIDTH(4), .LANE_WIDTH(32), .LANE_COUNT(3), .READ_LATENCY(1), .CLEAR_ON_RESET(1'b1)) u1 (
    .clk(clk), .reset(reset), .wea(wea), .wlane(wlane), .addra(addra), .dina(dina),
    .renb(renb), .addrb(addrb), .doutb(d1), .doutbValid(v1), .clearReq(clearReq),
    .clearBusy(b1), .writeDropped(wd1), .dropAck(dropAck));

  fofb_data_dpram_lanes #(.ADDR_WIDTH(4), .LANE_WIDTH(32), .LANE_COUNT(3), .READ_LATENCY(2), .CLEAR_ON_RESET(1'b0)) u2 (
    .clk(clk), .reset(reset), .wea(wea), .wlane(wlane), .addra(addra), .dina(dina),
    .renb(renb), .addrb(addrb), .doutb(d2), .doutbValid(v2), .clearReq(clearReq),
    .clearBusy(b2), .writeDropped(wd2), .dropAck(dropAck));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [95:0] obs, input logic [95:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [95:0] pat(input int a);
    return {3{32'h100 + 32'(a)}};
  endfunction

  function automatic logic [95:0] after_abort(input int a);
    return a == 3 ? 96'h77 : (a <= 5 ? 96'h0 : pat(a));
  endfunction

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; wea = 1'b0; renb = 1'b0; clearReq = 1'b0; dropAck = 1'b0;
    wlane = '0; addra = '0; addrb = '0; dina = '0;
    repeat (3) tick;
    chk("rst_d1", d1, 96'h0);
    chk("rst_v1", v1, 1'b0);
    chk("rst_wd1", wd1, 1'b0);
    chk("rst_b1", b1, 1'b1);
    chk("rst_b2", b2, 1'b0);
    chk("rst_d2", d2, 96'h0);
    chk("rst_v2", v2, 1'b0);
    reset = 1'b0;
    n = 0;
    while (b1 && n < 40) begin tick; n++; end
    chk("por_clear_cycles", n, 16);
    chk("por_b2_idle", b2, 1'b0);
    clearReq = 1'b1;
    tick;
    clearReq = 1'b0;
    n = 0;
    while (b2 && n < 40) begin n++; tick; end
    chk("req_clear_cycles", n, 16);
    renb = 1'b1;
    for (int a = 0; a < 16; a++) begin
      addrb = 4'(a);
      tick;
      chk("zero_v1", v1, 1'b1);
      chk("zero_d1", d1, 96'h0);
      if (a >= 1) begin
        chk("zero_v2", v2, 1'b1);
        chk("zero_d2", d2, 96'h0);
      end
    end
    renb = 1'b0;
    tick;
    chk("zero_v1_end", v1, 1'b0);
    chk("zero_v2_last", v2, 1'b1);
    tick;
    chk("zero_v2_end", v2, 1'b0);
    wea = 1'b1; wlane = 3'b111; addra = 4'd5; dina = {32'hA, 32'hB, 32'hC};
    tick;
    wlane = 3'b010; dina = {32'h1, 32'h2, 32'h3};
    tick;
    wlane = 3'b000; dina = '1;
    tick;
    wea = 1'b0; renb = 1'b1; addrb = 4'd5;
    tick;
    renb = 1'b0;
    chk("lane_v1", v1, 1'b1);
    chk("lane_d1", d1, {32'hA, 32'h2, 32'hC});
    chk("lane_v2_early", v2, 1'b0);
    tick;
    chk("lane_v2", v2, 1'b1);
    chk("lane_d2", d2, {32'hA, 32'h2, 32'hC});
    chk("lane_v1_off", v1, 1'b0);
    chk("lane_d1_hold", d1, {32'hA, 32'h2, 32'hC});
    wea = 1'b1; wlane = 3'b111;
    for (int a = 1; a <= 4; a++) begin
      addra = 4'(a); dina = pat(a);
      tick;
    end
    wea = 1'b0;
    for (int a = 1; a <= 5; a++) begin
      renb = a <= 4; addrb = 4'(a);
      tick;
      if (a >= 2) begin
        chk("burst_v2", v2, 1'b1);
        chk("burst_d2", d2, pat(a - 1));
      end else chk("burst_v2_lat", v2, 1'b0);
    end
    tick;
    chk("burst_v2_end", v2, 1'b0);
    chk("burst_d2_hold", d2, pat(4));
    wea = 1'b1; wlane = 3'b001; addra = 4'd7; dina = {64'h0, 32'h55};
    renb = 1'b1; addrb = 4'd7;
    tick;
    wea = 1'b0;
    chk("rfirst_old", d1, 96'h0);
    tick;
    renb = 1'b0;
    chk("rfirst_new", d1, 96'h55);
    clearReq = 1'b1;
    tick;
    clearReq = 1'b0;
    tick;
    tick;
    wea = 1'b1; wlane = 3'b111; addra = 4'd0; dina = '1;
    tick;
    chk("drop_set1", wd1, 1'b1);
    chk("drop_set2", wd2, 1'b1);
    clearReq = 1'b1; dropAck = 1'b1;
    tick;
    clearReq = 1'b0; dropAck = 1'b0; wea = 1'b0;
    chk("drop_prio", wd1, 1'b1);
    n = 4;
    while (b1 && n < 40) begin tick; n++; end
    chk("clear_no_extend", n, 16);
    chk("drop_sticky", wd1, 1'b1);
    renb = 1'b1; addrb = 4'd0;
    tick;
    renb = 1'b0;
    chk("drop_not_written", d1, 96'h0);
    dropAck = 1'b1;
    tick;
    dropAck = 1'b0;
    chk("drop_ack", wd1, 1'b0);
    wea = 1'b1; wlane = 3'b111;
    for (int a = 0; a < 8; a++) begin
      addra = 4'(a); dina = pat(a);
      tick;
    end
    wea = 1'b0;
    clearReq = 1'b1;
    tick;
    clearReq = 1'b0;
    repeat (6) tick;
    reset = 1'b1;
    #1;
    chk("abort_b2", b2, 1'b0);
    chk("abort_v2", v2, 1'b0);
    chk("abort_b1", b1, 1'b1);
    tick;
    reset = 1'b0;
    chk("abort_idle", b2, 1'b0);
    wea = 1'b1; addra = 4'd3; dina = 96'h77;
    tick;
    wea = 1'b0;
    for (int a = 0; a <= 8; a++) begin
      renb = a <= 7; addrb = 4'(a);
      tick;
      if (a >= 1) begin
        chk("abort_rd_v2", v2, 1'b1);
        chk("abort_rd_d2", d2, after_abort(a - 1));
      end
    end
    renb = 1'b0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
